counter_event_fifo: RTL

//   Sits directly downstream of the free-running counter; consumes its count bus.
//   Per cycle, detects two events on the count value:
//     - compare match against a programmable value
//     - wrap-around, e.g. 7->0 for a 3-bit counter

---
 rtl/counter_event_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/counter_event_fifo.sv
// Event detector and record FIFO fed by an upstream counter's count bus.
// Optional saturating drop counter enabled by defining CEF_DROP_CNT_EN.
module counter_event_fifo #(
    parameter int CNT_W = 3,
    parameter int TS_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CNT_W-1:0]          count_in,
    input  logic [CNT_W-1:0]          cmp_val,
    input  logic                      cmp_en,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [2+CNT_W+TS_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [7:0]                drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = 2 + CNT_W + TS_W;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] prev_q;
    logic             primed_q;
    logic [REC_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;

    logic             match, wrap, push, pop, full, accept, drop;
    logic [REC_W-1:0] rec;

    always_comb begin
        match  = primed_q && cmp_en && (count_in == cmp_val) && (count_in != prev_q);
        wrap   = primed_q && (count_in < prev_q);
        push   = match || wrap;
        rec    = {wrap, match, count_in, ts_q};
        pop    = (level_q != '0) && out_ready;
        full   = (level_q == LVL_W'(DEPTH));
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        accept = push && (!full || pop);
        drop   = push && full && !pop;
    end

    always_comb begin
        ts_d     = ts_q + TS_W'(1);
        wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (accept && !pop)
            level_d = level_q + LVL_W'(1);
        else if (!accept && pop)
            level_d = level_q - LVL_W'(1);
        ovf_d    = ovf_q || drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            prev_q   <= '0;
            primed_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            prev_q   <= count_in;
            primed_q <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; stale entries are masked by out_valid below.
    always_ff @(posedge clk) begin
        if (!rst && accept)
            mem_q[wr_ptr_q] <= rec;
    end

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign overflow  = ovf_q;

`ifdef CEF_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (drop && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            drop_q <= '0;
        else
            drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule
